// File: rtl/busarb_pkg.sv
// busarb_pkg: shared types and constants for the Unibus arbiter.
// Used by busarb and busarb_prio.
package busarb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    SELECTED,
    NPBUSY,
    VECSSYN,
    GAP
  } state_t;

  localparam logic [2:0] LEV4 = 3'd4;
  localparam logic [2:0] LEV5 = 3'd5;
  localparam logic [2:0] LEV6 = 3'd6;
  localparam logic [2:0] LEV7 = 3'd7;

  localparam logic [3:0] BG_OFF = 4'b1111;

  // Active-low grant word for a BR level 4..7.
  function automatic logic [3:0] bg_mask(
    input logic [2:0] lev
  );
    logic [3:0] m;
    m = BG_OFF;
    m[lev[1:0]] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/busarb_prio.sv
// busarb_prio: combinational request priority select.
// NPR is considered only when BUSARB_NPR_EN is defined.
module busarb_prio
  import busarb_pkg::*;
(
  input  logic [3:0] br_in_h,
  input  logic       npr_in_h,
  input  logic [2:0] cpu_pri,
  input  logic       cpu_intok,
  input  logic       intpend,
  output logic       win_vld,
  output logic       win_npr,
  output logic [2:0] win_lev
);

  logic       npr_ok;
  logic       br_ok;
  logic [3:0] elig;

`ifdef BUSARB_NPR_EN
  assign npr_ok = npr_in_h;
`else
  logic unused_npr;
  assign unused_npr = npr_in_h;
  assign npr_ok = 1'b0;
`endif

  assign br_ok = ~npr_ok & cpu_intok & ~intpend;

  // A BR line is eligible only above the processor priority.
  always_comb begin
    elig    = '0;
    elig[3] = br_in_h[3] & (LEV7 > cpu_pri);
    elig[2] = br_in_h[2] & (LEV6 > cpu_pri);
    elig[1] = br_in_h[1] & (LEV5 > cpu_pri);
    elig[0] = br_in_h[0] & (LEV4 > cpu_pri);
  end

  // NPR first, then the highest eligible BR level.
  always_comb begin
    win_vld = 1'b0;
    win_npr = 1'b0;
    win_lev = LEV4;
    unique case (1'b1)
      npr_ok: begin
        win_vld = 1'b1;
        win_npr = 1'b1;
      end
      br_ok & elig[3]: begin
        win_vld = 1'b1;
        win_lev = LEV7;
      end
      br_ok & elig[2] & ~elig[3]: begin
        win_vld = 1'b1;
        win_lev = LEV6;
      end
      br_ok & elig[1] & ~|elig[3:2]: begin
        win_vld = 1'b1;
        win_lev = LEV5;
      end
      br_ok & elig[0] & ~|elig[3:1]: begin
        win_vld = 1'b1;
        win_lev = LEV4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/busarb.sv
// busarb: Unibus grant arbiter and interrupt-vector receiver.
// Define BUSARB_NPR_EN to enable NPR/NPG and the NPBUSY state.
module busarb
  import busarb_pkg::*;
#(
  parameter int GRANT_TMO = 64
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        init_in_h,
  input  logic [3:0]  br_in_h,
  input  logic        npr_in_h,
  input  logic        sack_in_h,
  input  logic        bbsy_in_h,
  input  logic        intr_in_h,
  input  logic [15:0] d_in_h,
  input  logic [2:0]  cpu_pri,
  input  logic        cpu_intok,
  input  logic        cpu_intack,
  output logic [3:0]  bg_out_l,
  output logic        npg_out_l,
  output logic        ssyn_out_h,
  output logic [7:0]  intvec_out,
  output logic [2:0]  intlev_out,
  output logic        intpend_out
);

  localparam int TW = $clog2(GRANT_TMO);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(GRANT_TMO - 1);

  state_t          state_q;
  state_t          state_d;
  logic [TW-1:0]   tmr_q;
  logic [TW-1:0]   tmr_d;
  logic [2:0]      lev_q;
  logic [2:0]      lev_d;
  logic            npr_q;
  logic            npr_d;
  logic            cap;
  logic            pend_set;
  logic [3:0]      bg_d;
  logic            npg_d;

  logic            win_vld;
  logic            win_npr;
  logic [2:0]      win_lev;

  logic            unused_d;
  assign unused_d = ^{d_in_h[15:8], d_in_h[1:0]};

  busarb_prio u_prio (
    .br_in_h   (br_in_h),
    .npr_in_h  (npr_in_h),
    .cpu_pri   (cpu_pri),
    .cpu_intok (cpu_intok),
    .intpend   (intpend_out),
    .win_vld   (win_vld),
    .win_npr   (win_npr),
    .win_lev   (win_lev)
  );

  // Next state, grant timer and winner bookkeeping.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    lev_d    = lev_q;
    npr_d    = npr_q;
    cap      = 1'b0;
    pend_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          tmr_d   = '0;
          lev_d   = win_lev;
          npr_d   = win_npr;
        end
      end
      GRANT: begin
        if (sack_in_h) begin
          tmr_d = '0;
`ifdef BUSARB_NPR_EN
          state_d = npr_q ? NPBUSY : SELECTED;
`else
          state_d = SELECTED;
`endif
        end else if (tmr_q == TMO_LAST) begin
          tmr_d   = '0;
          state_d = GAP;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      SELECTED: begin
        if (bbsy_in_h && intr_in_h) begin
          cap     = 1'b1;
          state_d = VECSSYN;
        end else if (!sack_in_h && !bbsy_in_h) begin
          state_d = GAP;
        end
      end
      VECSSYN: begin
        if (!intr_in_h) begin
          pend_set = 1'b1;
          state_d  = GAP;
        end
      end
`ifdef BUSARB_NPR_EN
      NPBUSY: begin
        if (!sack_in_h && !bbsy_in_h) begin
          state_d = GAP;
        end
      end
`endif
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant lines follow the next state so they are registered.
  always_comb begin
    bg_d  = BG_OFF;
    npg_d = 1'b1;
    if (state_d == GRANT) begin
      if (npr_d) begin
        npg_d = 1'b0;
      end else begin
        bg_d = bg_mask(lev_d);
      end
    end
  end

  // State, grant, handshake and vector registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      lev_q       <= LEV4;
      npr_q       <= 1'b0;
      bg_out_l    <= BG_OFF;
      npg_out_l   <= 1'b1;
      ssyn_out_h  <= 1'b0;
      intvec_out  <= '0;
      intlev_out  <= '0;
      intpend_out <= 1'b0;
    end else if (init_in_h) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      lev_q       <= LEV4;
      npr_q       <= 1'b0;
      bg_out_l    <= BG_OFF;
      npg_out_l   <= 1'b1;
      ssyn_out_h  <= 1'b0;
      intvec_out  <= '0;
      intlev_out  <= '0;
      intpend_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      lev_q      <= lev_d;
      npr_q      <= npr_d;
      bg_out_l   <= bg_d;
      npg_out_l  <= npg_d;
      ssyn_out_h <= (state_d == VECSSYN);
      if (cap) begin
        intvec_out <= {d_in_h[7:2], 2'b00};
        intlev_out <= lev_q;
      end
      if (pend_set) begin
        intpend_out <= 1'b1;
      end else if (cpu_intack) begin
        intpend_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_busarb.sv
// tb_busarb: directed vector table plus corner sequences.
// Exercises the NPR path when BUSARB_NPR_EN is defined.
module tb_busarb;

  localparam int TMO = 64;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        init_in_h;
  logic [3:0]  br_in_h;
  logic        npr_in_h;
  logic        sack_in_h;
  logic        bbsy_in_h;
  logic        intr_in_h;
  logic [15:0] d_in_h;
  logic [2:0]  cpu_pri;
  logic        cpu_intok;
  logic        cpu_intack;
  logic [3:0]  bg_out_l;
  logic        npg_out_l;
  logic        ssyn_out_h;
  logic [7:0]  intvec_out;
  logic [2:0]  intlev_out;
  logic        intpend_out;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0]  br;
    logic [3:0]  ctl;
    logic [15:0] d;
    logic [2:0]  pri;
    logic        intok;
    logic [3:0]  bg;
    logic        ssyn;
    logic [7:0]  vec;
    logic [2:0]  lev;
    logic        pend;
  } row_t;

  row_t rows[$];

  busarb #(.GRANT_TMO(TMO)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .init_in_h   (init_in_h),
    .br_in_h     (br_in_h),
    .npr_in_h    (npr_in_h),
    .sack_in_h   (sack_in_h),
    .bbsy_in_h   (bbsy_in_h),
    .intr_in_h   (intr_in_h),
    .d_in_h      (d_in_h),
    .cpu_pri     (cpu_pri),
    .cpu_intok   (cpu_intok),
    .cpu_intack  (cpu_intack),
    .bg_out_l    (bg_out_l),
    .npg_out_l   (npg_out_l),
    .ssyn_out_h  (ssyn_out_h),
    .intvec_out  (intvec_out),
    .intlev_out  (intlev_out),
    .intpend_out (intpend_out)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic clr();
    br_in_h    = '0;
    npr_in_h   = 1'b0;
    sack_in_h  = 1'b0;
    bbsy_in_h  = 1'b0;
    intr_in_h  = 1'b0;
    d_in_h     = '0;
    cpu_intack = 1'b0;
  endtask

  task automatic add(input logic [3:0] br,
                     input logic [3:0] ctl,
                     input logic [15:0] d,
                     input logic [2:0] pri,
                     input logic intok,
                     input logic [3:0] bg,
                     input logic ssyn,
                     input logic [7:0] vec,
                     input logic [2:0] lev,
                     input logic pend);
    row_t r;
    r.br = br; r.ctl = ctl; r.d = d;
    r.pri = pri; r.intok = intok;
    r.bg = bg; r.ssyn = ssyn; r.vec = vec;
    r.lev = lev; r.pend = pend;
    rows.push_back(r);
  endtask

  task automatic chk_all(input string p,
                         input logic [3:0] bg,
                         input logic ssyn,
                         input logic [7:0] vec,
                         input logic [2:0] lev,
                         input logic pend);
    chk({p, " bg"}, {12'b0, bg_out_l}, {12'b0, bg});
    chk({p, " npg"}, {15'b0, npg_out_l}, 16'h1);
    chk({p, " ssyn"}, {15'b0, ssyn_out_h},
        {15'b0, ssyn});
    chk({p, " vec"}, {8'b0, intvec_out}, {8'b0, vec});
    chk({p, " lev"}, {13'b0, intlev_out}, {13'b0, lev});
    chk({p, " pend"}, {15'b0, intpend_out},
        {15'b0, pend});
  endtask

  initial begin
    int cnt;
    // ctl = {sack, bbsy, intr, intack}
    // BR5 interrupt with vector capture
    add(4'b0010, 4'b0000, 16'h0000, 3'd4, 1'b1,
        4'b1101, 1'b0, 8'h00, 3'd0, 1'b0);
    add(4'b0010, 4'b1000, 16'h0000, 3'd4, 1'b1,
        4'b1111, 1'b0, 8'h00, 3'd0, 1'b0);
    add(4'b0000, 4'b1110, 16'h0035, 3'd4, 1'b1,
        4'b1111, 1'b1, 8'h34, 3'd5, 1'b0);
    add(4'b0000, 4'b1110, 16'h0035, 3'd4, 1'b1,
        4'b1111, 1'b1, 8'h34, 3'd5, 1'b0);
    add(4'b0000, 4'b0100, 16'h0000, 3'd4, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b1);
    add(4'b0000, 4'b0000, 16'h0000, 3'd4, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b1);
    // pending vector blocks BR grants
    add(4'b1000, 4'b0000, 16'h0000, 3'd4, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b1);
    add(4'b1000, 4'b0001, 16'h0000, 3'd4, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b0);
    add(4'b1000, 4'b0000, 16'h0000, 3'd4, 1'b1,
        4'b0111, 1'b0, 8'h34, 3'd5, 1'b0);
    // passive release: nothing latched
    add(4'b1000, 4'b1000, 16'h0000, 3'd4, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b0);
    add(4'b0000, 4'b0000, 16'h0000, 3'd4, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b0);
    add(4'b0000, 4'b0000, 16'h0000, 3'd4, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b0);
    // BR4+BR6 at pri 5: BG6 only
    add(4'b0101, 4'b0000, 16'h0000, 3'd5, 1'b1,
        4'b1011, 1'b0, 8'h34, 3'd5, 1'b0);
    add(4'b0101, 4'b1000, 16'h0000, 3'd5, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b0);
    add(4'b0101, 4'b1100, 16'h0000, 3'd5, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b0);
    add(4'b0000, 4'b0000, 16'h0000, 3'd5, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b0);
    add(4'b0000, 4'b0000, 16'h0000, 3'd5, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b0);
    // priority boundaries and cpu_intok
    add(4'b0001, 4'b0000, 16'h0000, 3'd5, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b0);
    add(4'b0001, 4'b0000, 16'h0000, 3'd4, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b0);
    add(4'b1000, 4'b0000, 16'h0000, 3'd5, 1'b0,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b0);
    add(4'b1000, 4'b0000, 16'h0000, 3'd7, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b0);
    add(4'b0001, 4'b0000, 16'h0000, 3'd3, 1'b1,
        4'b1110, 1'b0, 8'h34, 3'd5, 1'b0);
    // SACK+BBSY+INTR at grant release
    add(4'b0000, 4'b1110, 16'hABFE, 3'd3, 1'b1,
        4'b1111, 1'b0, 8'h34, 3'd5, 1'b0);
    add(4'b0000, 4'b1110, 16'hABFE, 3'd3, 1'b1,
        4'b1111, 1'b1, 8'hFC, 3'd4, 1'b0);
    add(4'b0000, 4'b0000, 16'h0000, 3'd3, 1'b1,
        4'b1111, 1'b0, 8'hFC, 3'd4, 1'b1);
    add(4'b0000, 4'b0001, 16'h0000, 3'd3, 1'b1,
        4'b1111, 1'b0, 8'hFC, 3'd4, 1'b0);
    add(4'b0000, 4'b0001, 16'h0000, 3'd3, 1'b1,
        4'b1111, 1'b0, 8'hFC, 3'd4, 1'b0);

    clr();
    RESET     = 1'b1;
    init_in_h = 1'b0;
    cpu_pri   = 3'd0;
    cpu_intok = 1'b0;
    step();
    step();
    chk_all("reset", 4'b1111, 1'b0, 8'h00, 3'd0, 1'b0);
    RESET = 1'b0;
    step();
    chk_all("post", 4'b1111, 1'b0, 8'h00, 3'd0, 1'b0);

    foreach (rows[i]) begin
      br_in_h    = rows[i].br;
      sack_in_h  = rows[i].ctl[3];
      bbsy_in_h  = rows[i].ctl[2];
      intr_in_h  = rows[i].ctl[1];
      cpu_intack = rows[i].ctl[0];
      d_in_h     = rows[i].d;
      cpu_pri    = rows[i].pri;
      cpu_intok  = rows[i].intok;
      step();
      chk_all($sformatf("row%0d", i), rows[i].bg,
              rows[i].ssyn, rows[i].vec,
              rows[i].lev, rows[i].pend);
    end

    // INIT clears like reset, one edge later
    clr();
    cpu_pri   = 3'd4;
    cpu_intok = 1'b1;
    br_in_h   = 4'b0010;
    step();
    chk_all("init_g", 4'b1101, 1'b0, 8'hFC, 3'd4, 1'b0);
    init_in_h = 1'b1;
    step();
    chk_all("init", 4'b1111, 1'b0, 8'h00, 3'd0, 1'b0);
    init_in_h = 1'b0;
    step();
    chk_all("init_r", 4'b1101, 1'b0, 8'h00, 3'd0, 1'b0);
    br_in_h   = '0;
    sack_in_h = 1'b1;
    step();
    sack_in_h = 1'b0;
    step();
    step();

    // grant timeout, GAP, then re-grant
    cpu_pri = 3'd0;
    br_in_h = 4'b1000;
    step();
    chk("tmo_g", {12'b0, bg_out_l}, 16'h0007);
    cnt = 1;
    for (int k = 0; k < 2 * TMO; k++) begin
      step();
      if (bg_out_l == 4'b0111) cnt++;
      else break;
    end
    chk("tmo_len", 16'(cnt), 16'(TMO));
    step();
    chk("tmo_gap", {12'b0, bg_out_l}, 16'h000F);
    step();
    chk("tmo_re", {12'b0, bg_out_l}, 16'h0007);
    br_in_h   = '0;
    sack_in_h = 1'b1;
    step();
    sack_in_h = 1'b0;
    step();
    step();

`ifdef BUSARB_NPR_EN
    // NPR beats BR7; BG7 after DMA ends
    br_in_h  = 4'b1000;
    npr_in_h = 1'b1;
    step();
    chk("npg0", {15'b0, npg_out_l}, 16'h0);
    chk("npg_bg", {12'b0, bg_out_l}, 16'h000F);
    sack_in_h = 1'b1;
    step();
    chk("npg1", {15'b0, npg_out_l}, 16'h1);
    npr_in_h  = 1'b0;
    bbsy_in_h = 1'b1;
    step();
    sack_in_h = 1'b0;
    step();
    chk("npbusy", {12'b0, bg_out_l}, 16'h000F);
    bbsy_in_h = 1'b0;
    step();
    chk("np_gap", {12'b0, bg_out_l}, 16'h000F);
    step();
    chk("np_idle", {12'b0, bg_out_l}, 16'h000F);
    step();
    chk("np_bg7", {12'b0, bg_out_l}, 16'h0007);
    chk("np_npg", {15'b0, npg_out_l}, 16'h1);
`else
    // NPR ignored without the NPR option
    br_in_h  = 4'b1000;
    npr_in_h = 1'b1;
    step();
    chk("nonpr_bg", {12'b0, bg_out_l}, 16'h0007);
    chk("nonpr_npg", {15'b0, npg_out_l}, 16'h1);
`endif
    clr();
    sack_in_h = 1'b1;
    step();
    sack_in_h = 1'b0;
    step();
    step();

    // async reset mid-VECSSYN
    cpu_pri = 3'd4;
    br_in_h = 4'b0010;
    step();
    br_in_h   = '0;
    sack_in_h = 1'b1;
    step();
    bbsy_in_h = 1'b1;
    intr_in_h = 1'b1;
    d_in_h    = 16'h0035;
    step();
    chk("vs_ssyn", {15'b0, ssyn_out_h}, 16'h1);
    #2;
    RESET = 1'b1;
    #1;
    chk_all("arst", 4'b1111, 1'b0, 8'h00, 3'd0, 1'b0);
    clr();
    step();
    RESET = 1'b0;
    step();
    chk_all("arst_r", 4'b1111, 1'b0, 8'h00, 3'd0, 1'b0);
    cpu_pri = 3'd0;
    br_in_h = 4'b1000;
    step();
    chk("arst_g", {12'b0, bg_out_l}, 16'h0007);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/busarb.md
# busarb

Unibus arbitrator and interrupt-vector receiver on the CPU side of the bus. It watches BR7..BR4 and NPR, issues exactly one grant at a time (BG7..BG4 or NPG), tracks SACK/BBSY hand-off, and on an interrupt transaction latches the vector from the data lines and completes the INTR/SSYN handshake. The captured vector and level are then presented to the CPU core until it acknowledges them. It is the counterpart of each per-level interrupt requester on the bus.

## Interface
- GRANT_TMO, 64: cycles a grant is held without SACK before it is withdrawn; must be ≥ 8.
- CLOCK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- init_in_h  in  1  bus INIT; synchronous clear, same effect as RESET
- br_in_h  in  4  bus requests, bit n-4 = BRn
- npr_in_h  in  1  non-processor request
- sack_in_h  in  1  selection acknowledge
- bbsy_in_h  in  1  bus busy
- intr_in_h  in  1  interrupt strobe
- d_in_h  in  16  bus data
- cpu_pri  in  3  current processor priority
- cpu_intok  in  1  CPU is between instructions; BR grants permitted
- cpu_intack  in  1  one-cycle pulse: CPU has taken the pending vector
- bg_out_l  out  4  bus grants, active low, bit n-4 = BGn
- npg_out_l  out  1  NPR grant, active low
- ssyn_out_h  out  1  slave sync for the vector read
- intvec_out  out  8  captured vector, {d[7:2], 2'b00}
- intlev_out  out  3  level (4..7) of the captured vector
- intpend_out  out  1  vector valid, awaiting cpu_intack

## Operation
- States: IDLE, GRANT, SELECTED, NPBUSY, VECSSYN, GAP.
- IDLE: NPR beats every BR, ignoring cpu_pri and cpu_intok. Else highest BRn with n > cpu_pri, only when cpu_intok=1 and intpend_out=0. Winner latched; its grant asserted next cycle → GRANT.
- GRANT: grant held low. sack_in_h=1 → drop grant, timer cleared → SELECTED (BR) or NPBUSY (NPR). Timer reaches GRANT_TMO without SACK → drop grant → GAP.
- SELECTED: bbsy_in_h & intr_in_h → latch vector {d_in_h[7:2],00} and level, assert ssyn_out_h → VECSSYN. sack_in_h=0 & bbsy_in_h=0 (passive release: requester withdrew) → GAP, nothing latched.
- VECSSYN: ssyn held until intr_in_h=0; then ssyn drops, intpend_out=1 → GAP.
- NPBUSY: waits until sack_in_h=0 and bbsy_in_h=0 (DMA master done) → GAP.
- GAP: one cycle, all grants high → IDLE. Guarantees bg_out_l high for ≥1 cycle between grants.
- intpend_out clears on cpu_intack; intvec_out/intlev_out hold their value until the next capture. cpu_intack with intpend_out=0 ignored.
- Requests dropping during GRANT do not cancel the grant; timeout covers it.

## Timing
- Reset/INIT: bg_out_l=4'b1111, npg_out_l=1, ssyn_out_h=0, intvec_out=0, intlev_out=0, intpend_out=0, state IDLE. Mid-transaction reset drops all outputs immediately (async) or next edge (INIT).
- All outputs registered. Request-to-grant: 1 cycle (request sampled in IDLE, grant low the following edge).
- SACK-to-grant-release: 1 cycle. Requesters deglitch grants for 5 cycles; GRANT_TMO ≥ 8 preserves that.
- INTR&BBSY seen → ssyn high next edge, vector valid same edge. INTR low → ssyn low next edge; intpend_out high same edge.
- SACK and BBSY rising in the same cycle a grant is released: handled as SELECTED entry, then vector capture next cycle.

## Configuration
- BUSARB_NPR_EN defined: NPR/NPG arbitration and NPBUSY state present as above.
- Undefined: npr_in_h ignored, npg_out_l constant 1, NPBUSY unreachable/removed; BR behaviour unchanged.

## Structure
- Package busarb_pkg: state enum, level constants (LEV4..LEV7), grant-all-off constant 4'b1111.
- Sub-module busarb_prio: combinational priority select (br_in_h, npr_in_h, cpu_pri, cpu_intok, intpend) → winner valid, is-NPR, level.

## Test plan
- BR5 with cpu_pri=4, cpu_intok=1 → bg_out_l=4'b1101 next cycle; SACK → 4'b1111; BBSY+INTR, d=0o000064 → ssyn=1, intvec_out=0o064, intlev_out=5; INTR low → ssyn=0, intpend_out=1; cpu_intack → intpend_out=0.
- BR4 and BR6 together, cpu_pri=5 → only BG6 granted; BR4 never granted while cpu_pri ≥ 4.
- NPR and BR7 together (NPR_EN) → npg_out_l=0 first; after SACK, BBSY high then low → GAP, then BG7.
- BR7 granted, no SACK → grant withdrawn exactly GRANT_TMO cycles later, one GAP cycle, re-grant if BR7 still high.
- SACK then SACK low with no BBSY (passive release) → return to IDLE, intpend_out stays 0.
- RESET asserted during VECSSYN → ssyn_out_h and all grants inactive without a clock edge; IDLE after release.
